// File: rtl/lru_set_tracker.sv
// True-LRU replacement tracker: per-set age permutation plus valid/lock bits,
// with a registered victim query (invalid unlocked way first, else oldest unlocked).
module lru_set_tracker #(
    parameter int SETS  = 16,
    parameter int WAYS  = 8,
    parameter int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_v,
    input  logic [SET_W-1:0] acc_set,
    input  logic [WAY_W-1:0] acc_way,
    input  logic             acc_fill,
    input  logic             inv_v,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             lck_v,
    input  logic [SET_W-1:0] lck_set,
    input  logic [WAY_W-1:0] lck_way,
    input  logic             lck_val,
    input  logic             qry_v,
    input  logic [SET_W-1:0] qry_set,
    output logic             vic_v,
    output logic [WAY_W-1:0] vic_way,
    output logic             vic_none
);

    typedef struct packed {
        logic             pres;
        logic             inv;
        logic [WAY_W-1:0] age;
        logic [WAY_W-1:0] idx;
    } node_t;

    logic [WAY_W-1:0] age   [SETS][WAYS];
    logic [WAYS-1:0]  valid [SETS];
    logic [WAYS-1:0]  lock  [SETS];

    logic acc_ok, inv_ok, lck_ok, qry_ok;

    generate
        if (SETS == (1 << SET_W)) begin : g_full
            assign acc_ok = acc_v;
            assign inv_ok = inv_v;
            assign lck_ok = lck_v;
            assign qry_ok = qry_v;
        end else begin : g_part
            // Indices beyond SETS do not exist; such commands are dropped.
            assign acc_ok = acc_v && (acc_set < SET_W'(SETS));
            assign inv_ok = inv_v && (inv_set < SET_W'(SETS));
            assign lck_ok = lck_v && (lck_set < SET_W'(SETS));
            assign qry_ok = qry_v && (qry_set < SET_W'(SETS));
        end
    endgenerate

    // Left operand always covers lower way indices, so ties on "invalid" go left.
    function automatic node_t pick(input node_t l, input node_t r);
        if (!l.pres) return r;
        if (!r.pres) return l;
        if (l.inv)   return l;
        if (r.inv)   return r;
        return (r.age > l.age) ? r : l;
    endfunction

    logic [SET_W-1:0] qs;
    node_t            leaf [WAYS];
    node_t            root;

    assign qs = qry_ok ? qry_set : '0;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            leaf[w].pres = ~lock[qs][w];
            leaf[w].inv  = ~valid[qs][w];
            leaf[w].age  = age[qs][w];
            leaf[w].idx  = WAY_W'(w);
        end
    end

    genvar l, k;
    generate
        for (l = 1; l <= WAY_W; l++) begin : g_lvl
            node_t n [WAYS >> l];
            for (k = 0; k < (WAYS >> l); k++) begin : g_node
                if (l == 1) begin : g_leaf
                    assign n[k] = pick(leaf[2*k], leaf[2*k+1]);
                end else begin : g_inner
                    assign n[k] = pick(g_lvl[l-1].n[2*k], g_lvl[l-1].n[2*k+1]);
                end
            end
        end
    endgenerate

    assign root = g_lvl[WAY_W].n[0];

    logic [WAY_W-1:0] old_age;
    assign old_age = age[acc_set][acc_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
                valid[s] <= '0;
                lock[s]  <= '0;
            end
            vic_v    <= 1'b0;
            vic_way  <= '0;
            vic_none <= 1'b0;
        end else begin
            if (acc_ok) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (acc_way == WAY_W'(w))
                        age[acc_set][w] <= '0;
                    else if (age[acc_set][w] < old_age)
                        age[acc_set][w] <= age[acc_set][w] + 1'b1;
                end
            end
            // A same-way access overrides the invalidate; the fill set below then wins.
            if (inv_ok && !(acc_ok && acc_set == inv_set && acc_way == inv_way))
                valid[inv_set][inv_way] <= 1'b0;
            if (acc_ok && acc_fill)
                valid[acc_set][acc_way] <= 1'b1;
            if (lck_ok)
                lock[lck_set][lck_way] <= lck_val;

            vic_v <= qry_ok;
            if (qry_ok) begin
                vic_none <= ~root.pres;
                vic_way  <= root.pres ? root.idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_lru_set_tracker.sv
// Directed table-driven bench for lru_set_tracker (SETS=16, WAYS=8), with
// hand-computed victims and age snapshots plus a per-cycle permutation check.
module tb_lru_set_tracker;

    localparam int SETS  = 16;
    localparam int WAYS  = 8;
    localparam int SET_W = 4;
    localparam int WAY_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             acc_v, acc_fill, inv_v, lck_v, lck_val, qry_v;
    logic [SET_W-1:0] acc_set, inv_set, lck_set, qry_set;
    logic [WAY_W-1:0] acc_way, inv_way, lck_way;
    logic             vic_v, vic_none;
    logic [WAY_W-1:0] vic_way;

    int checks = 0;
    int errors = 0;
    int exp_way = 0;
    int exp_none = 0;
    bit started = 0;

    always #5 clk = ~clk;

    lru_set_tracker #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .acc_v(acc_v), .acc_set(acc_set), .acc_way(acc_way), .acc_fill(acc_fill),
        .inv_v(inv_v), .inv_set(inv_set), .inv_way(inv_way),
        .lck_v(lck_v), .lck_set(lck_set), .lck_way(lck_way), .lck_val(lck_val),
        .qry_v(qry_v), .qry_set(qry_set),
        .vic_v(vic_v), .vic_way(vic_way), .vic_none(vic_none)
    );

    typedef struct {
        bit av; int as; int aw; bit af;
        bit iv; int is; int iw;
        bit lv; int ls; int lw; bit lval;
        bit qv; int qs; int ew; bit en;
    } vec_t;

    vec_t vecs [43];

    function automatic vec_t mk(bit av, int as, int aw, bit af, bit iv, int is, int iw,
                                bit lv, int ls, int lw, bit lval, bit qv, int qs, int ew, bit en);
        vec_t v;
        v.av = av; v.as = as; v.aw = aw; v.af = af;
        v.iv = iv; v.is = is; v.iw = iw;
        v.lv = lv; v.ls = ls; v.lw = lw; v.lval = lval;
        v.qv = qv; v.qs = qs; v.ew = ew; v.en = en;
        return v;
    endfunction

    function automatic vec_t acc(int s, int w, bit f);
        return mk(1, s, w, f, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t qry(int s, int w, bit n);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, s, w, n);
    endfunction
    function automatic vec_t lck(int s, int w, bit val);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, s, w, val, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        acc_v = 0; acc_set = '0; acc_way = '0; acc_fill = 0;
        inv_v = 0; inv_set = '0; inv_way = '0;
        lck_v = 0; lck_set = '0; lck_way = '0; lck_val = 0;
        qry_v = 0; qry_set = '0;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            acc_v = vecs[i].av; acc_set = SET_W'(vecs[i].as); acc_way = WAY_W'(vecs[i].aw);
            acc_fill = vecs[i].af;
            inv_v = vecs[i].iv; inv_set = SET_W'(vecs[i].is); inv_way = WAY_W'(vecs[i].iw);
            lck_v = vecs[i].lv; lck_set = SET_W'(vecs[i].ls); lck_way = WAY_W'(vecs[i].lw);
            lck_val = vecs[i].lval;
            qry_v = vecs[i].qv; qry_set = SET_W'(vecs[i].qs);
            @(posedge clk); #1;
            if (vecs[i].qv) begin
                exp_way  = vecs[i].ew;
                exp_none = int'(vecs[i].en);
            end
            chk($sformatf("row%0d vic_v", i), int'(vic_v), int'(vecs[i].qv));
            chk($sformatf("row%0d vic_way", i), int'(vic_way), exp_way);
            chk($sformatf("row%0d vic_none", i), int'(vic_none), exp_none);
        end
        idle_inputs();
    endtask

    task automatic check_ages(input int s, input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7);
        int e [WAYS];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int w = 0; w < WAYS; w++)
            chk($sformatf("age set%0d way%0d", s, w), int'(dut.age[s][w]), e[w]);
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int s = 0; s < SETS; s++) begin
                logic [WAYS-1:0] seen;
                seen = '0;
                for (int w = 0; w < WAYS; w++) seen[dut.age[s][w]] = 1'b1;
                checks++;
                if (seen != {WAYS{1'b1}}) begin
                    errors++;
                    $display("FAIL perm set%0d: seen %b expected all ones", s, seen);
                end
            end
        end
    end

    initial begin
        vecs[0] = qry(3, 0, 0);
        for (int w = 0; w < 8; w++) vecs[1+w] = acc(1, w, 1);
        vecs[9]  = qry(1, 0, 0);
        vecs[10] = acc(1, 0, 0);
        vecs[11] = qry(1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0);
        vecs[13] = qry(1, 2, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 2, 0);
        for (int w = 2; w < 8; w++) vecs[13+w] = lck(1, w, 1);
        vecs[21] = qry(1, 0, 1);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1);
        for (int w = 2; w < 8; w++) vecs[22+w] = lck(1, w, 0);
        vecs[30] = mk(0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[31] = qry(1, 5, 0);
        vecs[32] = mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0);
        vecs[33] = qry(1, 2, 0);
        vecs[34] = mk(1, 1, 3, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[35] = qry(1, 2, 0);
        vecs[36] = acc(1, 3, 0);
        vecs[37] = acc(1, 3, 0);
        vecs[38] = acc(1, 6, 0);
        vecs[39] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 2, 0);
        vecs[40] = qry(1, 1, 0);
        vecs[41] = acc(2, 4, 1);
        vecs[42] = qry(2, 0, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1;
        chk("reset vic_v", int'(vic_v), 0);
        chk("reset vic_way", int'(vic_way), 0);
        chk("reset vic_none", int'(vic_none), 0);
        check_ages(5, 0, 1, 2, 3, 4, 5, 6, 7);

        run(0, 11);
        check_ages(1, 0, 7, 6, 5, 4, 3, 2, 1);
        run(12, 42);
        check_ages(1, 3, 7, 6, 1, 5, 2, 0, 4);
        check_ages(2, 1, 2, 3, 4, 0, 5, 6, 7);

        // Reset arriving together with a query discards the result.
        qry_v = 1; qry_set = 4'd1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst qry vic_v", int'(vic_v), 0);
        chk("rst qry vic_way", int'(vic_way), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post rst vic_v", int'(vic_v), 1);
        chk("post rst vic_way", int'(vic_way), 0);
        chk("post rst vic_none", int'(vic_none), 0);
        qry_v = 0;
        check_ages(1, 0, 1, 2, 3, 4, 5, 6, 7);
        check_ages(2, 0, 1, 2, 3, 4, 5, 6, 7);
        @(posedge clk); #1;
        chk("idle vic_v", int'(vic_v), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lru_set_tracker.md
Name: lru_set_tracker

Overview:
- Multi-set, true-LRU replacement tracker for a set-associative cache.
- Per set, it keeps a WAYS-entry age permutation plus per-way valid and lock bits.
- It answers registered victim queries: prefer an invalid unlocked way, otherwise the oldest unlocked way.
- Sits beside the cache tag array; the cache controller drives access/fill, invalidate, lock and query.

Parameters:
SETS, 16, number of sets tracked (>=1)
WAYS, 8, ways per set (power of two, >=2)
SET_W, $clog2(SETS) (min 1), set index width
WAY_W, $clog2(WAYS), way index and age width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
acc_v  in  1  access/fill strobe
acc_set  in  SET_W  set of access
acc_way  in  WAY_W  way touched
acc_fill  in  1  1 = fill: also marks way valid
inv_v  in  1  invalidate strobe
inv_set  in  SET_W  set to invalidate
inv_way  in  WAY_W  way to invalidate
lck_v  in  1  lock-update strobe
lck_set  in  SET_W  set for lock update
lck_way  in  WAY_W  way for lock update
lck_val  in  1  new lock bit (1 = pinned, never victim)
qry_v  in  1  victim query strobe
qry_set  in  SET_W  set queried
vic_v  out  1  victim result valid (pulse)
vic_way  out  WAY_W  selected victim way
vic_none  out  1  all ways of queried set locked; no victim

Behaviour:
- State per set s, way w:
  - age[s][w] is WAY_W bits; 0 = most recent, WAYS-1 = least recent.
  - valid[s][w] and lock[s][w] are single bits.
- Reset, applied when rst is high on a clk edge:
  - age[s][w]=w for every set; all valid=0; all lock=0.
  - vic_v=0, vic_way=0, vic_none=0.
  - Reset mid-operation discards any pending query result. The cycle after rst deasserts accepts new commands.
- Access, when acc_v is high (old = age[acc_set][acc_way]):
  - The touched way's age becomes 0.
  - Every other way in the same set with age < old increments by 1. Ways with age > old are unchanged.
  - The ages therefore remain a permutation of 0..WAYS-1 at all times, and no saturation logic is needed.
  - Accessing the way already at age 0 changes nothing.
  - If acc_fill=1, also set valid[acc_set][acc_way]=1.
  - Access does not alter lock bits.
- Invalidate, when inv_v is high: clear valid[inv_set][inv_way]. Ages and lock are unchanged.
- Lock update, when lck_v is high: lock[lck_set][lck_way] <= lck_val.
- Simultaneous commands:
  - Access and invalidate on the same set and way: access/fill wins, so the valid bit ends at acc_fill OR its old value.
  - Commands on different sets or ways all apply in the same cycle.
- Query, when qry_v is high:
  - Selection reads the pre-update state of qry_set (read-before-write for any same-cycle access, invalidate or lock).
  - Result is registered: vic_v is high exactly 1 cycle after qry_v; back-to-back queries give back-to-back results.
- Victim selection among unlocked ways of the queried set:
  - (a) lowest-index way with valid=0;
  - (b) otherwise, the way with age==WAYS-1 if unlocked; otherwise the unlocked way with the maximum age. The permutation guarantees a unique answer.
  - (c) If every way is locked, vic_none=1 and vic_way=0.
  - vic_none=0 whenever a victim exists.
- The tracker never auto-touches the victim; the controller must issue a fill access.
- Outputs hold their last values when vic_v=0 except vic_v itself. Out-of-range set indices (SETS not a power of two) are ignored.
- Implementation: the selection tree is combinational (log2(WAYS) compare levels) and the output is registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, WAYS=8 -> query set 3 -> next cycle vic_v=1, vic_way=0 (all invalid), vic_none=0.
2. Fill ways 0..7 of set 1 in order, then query set 1 -> vic_way=0. Access way 0 again, query -> vic_way=1. Check ages for set 1 are {0,7,6,5,4,3,2,1}.
3. After test 2, lock way 1 -> query -> vic_way=2. Lock all 8 ways -> vic_none=1, vic_way=0.
4. Set 1 fully valid, invalidate way 5 -> query -> vic_way=5. In the same cycle issue fill on set1/way5 and query set1: result still 5 (read-before-write); a following query returns 2.
5. Access way 3 twice back-to-back, then way 6 -> ages remain a permutation (assertion checked every cycle). Accesses to set 2 leave set 1 ages untouched.
6. Assert rst while qry_v is high -> vic_v=0 the next cycle, and all sets return to reset state (query any set gives vic_way=0).
